// File: rtl/tick_gen_prog.sv
// tick_gen_prog - programmable tick generator.
//
// Divides clk by a run-time divisor and emits a one-cycle o_tick strobe once
// per divisor period. A new divisor takes effect right away when the counter
// is idle or at zero. Otherwise it waits in a pending register and is applied
// on the next wrap, so a period is never cut short or stretched mid-way.
//
// Optional feature: define TICK_GEN_SQUARE_EN to add o_sq. This is a
// 50%-duty square wave at half the tick rate.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-high
//   i_en       count enable; the counter holds while low
//   i_clr      synchronous clear of counter/phase; applies any pending divisor
//   i_div_wr   one-cycle strobe that loads i_div as the new divisor
//   i_div      new divisor value (0 is treated as 1)
//   o_tick     one-cycle strobe, once per divisor period
//   o_div      divisor currently in effect
//   o_pend     a divisor write is waiting for the next period boundary
//   o_sq       (TICK_GEN_SQUARE_EN only) toggles on every tick
module tick_gen_prog #(
  parameter int          CNT_W       = 17,
  parameter int unsigned DIV_DEFAULT = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_div_wr,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_div,
  output logic             o_pend
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic             o_sq
`endif
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_pend;
  logic [CNT_W-1:0] div_new;
  logic [CNT_W-1:0] term;
  logic             pend;
  logic             tick;
  logic             wrap;

  // A zero divisor would give a terminal value of all-ones; force it to 1.
  assign div_new = (i_div == '0) ? CNT_W'(1) : i_div;
  assign term    = div_act - CNT_W'(1);
  assign wrap    = i_en && (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      div_act  <= CNT_W'(DIV_DEFAULT);
      div_pend <= '0;
      pend     <= 1'b0;
      tick     <= 1'b0;
    end else if (i_clr) begin
      cnt  <= '0;
      tick <= 1'b0;
      pend <= 1'b0;
      // A write in the same cycle as the clear wins over an older pending value.
      if (i_div_wr)
        div_act <= div_new;
      else if (pend)
        div_act <= div_pend;
    end else begin
      if (i_en) begin
        if (wrap) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt  <= cnt + CNT_W'(1);
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      if (i_div_wr) begin
        // Apply immediately when no period is in progress or this edge closes
        // the current one. Otherwise park the value until the next wrap.
        if (!i_en || (cnt == '0) || wrap) begin
          div_act <= div_new;
          pend    <= 1'b0;
        end else begin
          div_pend <= div_new;
          pend     <= 1'b1;
        end
      end else if (wrap && pend) begin
        div_act <= div_pend;
        pend    <= 1'b0;
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  logic sq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sq <= 1'b0;
    else if (i_clr)
      sq <= 1'b0;
    else if (wrap)
      sq <= ~sq;
  end

  assign o_sq = sq;
`endif

  assign o_tick = tick;
  assign o_div  = div_act;
  assign o_pend = pend;

endmodule

// File: tb/tb_tick_gen_prog.sv
module tb_tick_gen_prog;

  localparam int CNT_W = 17;
  localparam int DIV_D = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_en = 1'b0;
  logic             i_clr = 1'b0;
  logic             i_div_wr = 1'b0;
  logic [CNT_W-1:0] i_div = '0;
  logic             o_tick;
  logic [CNT_W-1:0] o_div;
  logic             o_pend;
`ifdef TICK_GEN_SQUARE_EN
  logic             o_sq;
`endif

  tick_gen_prog #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_D)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_en     (i_en),
    .i_clr    (i_clr),
    .i_div_wr (i_div_wr),
    .i_div    (i_div),
    .o_tick   (o_tick),
    .o_div    (o_div),
    .o_pend   (o_pend)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .o_sq     (o_sq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             clr;
    logic             wr;
    logic [CNT_W-1:0] div;
    logic             x_tick;
    logic [CNT_W-1:0] x_div;
    logic             x_pend;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic en, input logic clr, input logic wr, input int div,
                     input logic x_tick, input int x_div, input logic x_pend, input int rep = 1);
    vec_t v;
    v.en = en; v.clr = clr; v.wr = wr; v.div = CNT_W'(div);
    v.x_tick = x_tick; v.x_div = CNT_W'(x_div); v.x_pend = x_pend;
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic clr, input logic wr, input logic [CNT_W-1:0] div);
    i_en = en; i_clr = clr; i_div_wr = wr; i_div = div;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic sq_exp;
    int   edges;

    // Counter after each row is noted on the right.
    add(1,0,0,0,  0,5,0, 2);     // cnt 1,2
    add(0,0,0,0,  0,5,0, 7);     // hold at 2
    add(1,0,0,0,  0,5,0, 2);     // 3,4
    add(1,0,0,0,  1,5,0);        // wrap
    add(1,0,0,0,  0,5,0);        // 1
    add(0,0,1,10, 0,10,0);       // idle write, immediate
    add(1,1,0,0,  0,10,0);       // clear -> 0
    add(1,0,0,0,  0,10,0, 6);    // 1..6
    add(1,0,1,4,  0,10,1);       // write at 6 -> pending, cnt 7
    add(1,0,0,0,  0,10,1, 2);    // 8,9
    add(1,0,0,0,  1,4,0);        // wrap under old divisor, new applied
    add(1,0,0,0,  0,4,0, 3);     // 1..3
    add(1,0,0,0,  1,4,0);        // period 4
    add(1,0,0,0,  0,4,0);        // 1
    add(0,1,0,0,  0,4,0);        // clear -> 0
    add(0,0,1,0,  0,1,0);        // write 0 -> 1
    add(1,0,0,0,  1,1,0, 3);     // continuous tick
    add(0,1,1,8,  0,8,0);        // clear+write -> div 8
    add(1,0,0,0,  0,8,0, 5);     // 1..5
    add(1,1,1,3,  0,3,0);        // clear+write at 5
    add(1,0,0,0,  0,3,0, 2);     // 1,2
    add(1,0,0,0,  1,3,0);        // tick after 3 edges
    add(1,0,1,9,  0,9,0);        // write at 0 -> immediate, cnt 1
    add(1,0,1,6,  0,9,1);        // pending 6, cnt 2
    add(1,0,1,7,  0,9,1);        // last write wins, cnt 3
    add(1,0,0,0,  0,9,1, 5);     // 4..8
    add(1,0,0,0,  1,7,0);        // wrap applies 7
    add(1,0,0,0,  0,7,0, 6);     // 1..6
    add(1,0,0,0,  1,7,0);        // period 7
    add(1,0,0,0,  0,7,0);        // 1
    add(1,0,1,2,  0,7,1);        // pending 2, cnt 2
    add(1,1,0,0,  0,2,0);        // clear applies pending
    add(1,0,0,0,  0,2,0);        // 1
    add(1,0,0,0,  1,2,0);        // wrap

    #12;
    chk("rst_tick", 32'(o_tick), 32'd0);
    chk("rst_div",  32'(o_div),  32'(DIV_D));
    chk("rst_pend", 32'(o_pend), 32'd0);
`ifdef TICK_GEN_SQUARE_EN
    chk("rst_sq",   32'(o_sq),   32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    sq_exp = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].wr, vecs[i].div);
      chk($sformatf("v%0d_tick", i), 32'(o_tick), 32'(vecs[i].x_tick));
      chk($sformatf("v%0d_div",  i), 32'(o_div),  32'(vecs[i].x_div));
      chk($sformatf("v%0d_pend", i), 32'(o_pend), 32'(vecs[i].x_pend));
`ifdef TICK_GEN_SQUARE_EN
      if (vecs[i].clr)      sq_exp = 1'b0;
      else if (vecs[i].x_tick) sq_exp = ~sq_exp;
      chk($sformatf("v%0d_sq", i), 32'(o_sq), 32'(sq_exp));
`endif
    end

    // Reset while a divisor write is pending.
    step(1, 1, 1, 4);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 3);
    chk("pre_rst_pend", 32'(o_pend), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_pend", 32'(o_pend), 32'd0);
    chk("mid_rst_div",  32'(o_div),  32'(DIV_D));
    @(negedge clk);
    rst = 1'b0;

    // Reset while o_tick is high must drop it without a clock edge.
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    chk("pre_rst_tick", 32'(o_tick), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_tick", 32'(o_tick), 32'd0);
    chk("async_rst_div",  32'(o_div),  32'(DIV_D));
`ifdef TICK_GEN_SQUARE_EN
    chk("async_rst_sq",   32'(o_sq),   32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // After reset the first tick arrives on the DIV_D-th enabled edge.
    edges = 0;
    i_en = 1'b1; i_clr = 1'b0; i_div_wr = 1'b0; i_div = '0;
    for (int k = 1; k <= 3 * DIV_D; k++) begin
      @(posedge clk);
      #1;
      if (o_tick) begin
        edges = k;
        break;
      end
    end
    chk("first_tick_edge", 32'(edges), 32'(DIV_D));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
